// File: rtl/wc_pkg.sv
// Shared constants, sample type and transform matrices for the F(6,4) Winograd tile.
// Matrix entries come from constant functions evaluated at elaboration time.
package wc_pkg;

  localparam int W    = 10;
  localparam int R    = 4;
  localparam int M    = 6;
  localparam int N    = M + R - 1;
  localparam int NPTS = N - 1;
  localparam int DEN  = 5040;
  localparam int VW   = W + 12;
  localparam int UW   = W + 13;
  localparam int PW   = VW + UW;
  localparam int AW   = 2 * W + 26;

  typedef logic signed [W-1:0] sample_t;

  // Finite points 0,+1,-1,+2,-2,+3,-3,+4; index NPTS is the point at infinity.
  // Nine products need eight finite points, so +4 joins the symmetric set.
  function automatic int point(input int i);
    int p;
    case (i)
      0:       p = 0;
      1:       p = 1;
      2:       p = -1;
      3:       p = 2;
      4:       p = -2;
      5:       p = 3;
      6:       p = -3;
      default: p = 4;
    endcase
    return p;
  endfunction

  function automatic int ipow(input int b, input int e);
    int r;
    r = 1;
    for (int t = 0; t < e; t++) r = r * b;
    return r;
  endfunction

  // Lagrange denominator prod_{j!=i}(p_i - p_j); each one divides DEN.
  function automatic int lag_den(input int i);
    int r;
    r = 1;
    for (int j = 0; j < NPTS; j++)
      if (j != i) r = r * (point(i) - point(j));
    return r;
  endfunction

  // B^T[i][j]: coefficient of x^j in prod_{k!=i}(x - p_k); row NPTS uses all points.
  function automatic int bt_coef(input int i, input int j);
    int c [N+1];
    for (int t = 0; t <= N; t++) c[t] = 0;
    c[0] = 1;
    for (int k = 0; k < NPTS; k++) begin
      if (k != i) begin
        for (int t = N; t > 0; t--) c[t] = c[t-1] - point(k) * c[t];
        c[0] = -point(k) * c[0];
      end
    end
    return c[j];
  endfunction

  // A^T[r][i]: p_i^r, with the infinity column selecting only the top output.
  function automatic int at_coef(input int r, input int i);
    int a;
    if (i == NPTS) a = (r == M - 1) ? 1 : 0;
    else           a = ipow(point(i), r);
    return a;
  endfunction

  // Filter transform row i scaled by DEN so that every entry is an integer.
  function automatic int gt_coef(input int i, input int k);
    int g;
    if (i == NPTS) g = (k == R - 1) ? DEN : 0;
    else           g = (DEN / lag_den(i)) * ipow(point(i), k);
    return g;
  endfunction

  function automatic int g_xform(input int i, input int g0, input int g1,
                                 input int g2, input int g3);
    return gt_coef(i, 0) * g0 + gt_coef(i, 1) * g1 + gt_coef(i, 2) * g2 + gt_coef(i, 3) * g3;
  endfunction

endpackage

// File: rtl/wc_xform_in.sv
// Combinational input transform V = B^T * d for the F(6,4) tile.
// VW bits hold every row exactly: the row coefficient magnitudes sum to at most 2880.
module wc_xform_in
  import wc_pkg::*;
(
  input  sample_t              d [N],
  output logic signed [VW-1:0] v [N]
);

  for (genvar i = 0; i < N; i++) begin : g_row
    logic signed [VW-1:0] term [N];
    logic signed [VW-1:0] sum;

    for (genvar j = 0; j < N; j++) begin : g_col
      localparam int C = bt_coef(i, j);
      assign term[j] = VW'(C) * VW'(d[j]);
    end

    always_comb begin
      sum = '0;
      for (int j = 0; j < N; j++) sum = sum + term[j];
    end

    assign v[i] = sum;
  end

endmodule

// File: rtl/wc_core.sv
// F(6,4) Winograd correlation tile: y[i] = sum_k d[i+k]*Gk, wrapped to W bits.
// Three registered stages: input transform, element-wise products, output transform.
module wc_core
  import wc_pkg::*;
#(
  parameter int G0 = 1,
  parameter int G1 = 2,
  parameter int G2 = 3,
  parameter int G3 = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] D,
  output logic [M*W-1:0] Z
);

  sample_t              d       [N];
  logic signed [VW-1:0] v       [N];
  logic signed [VW-1:0] v_p1    [N];
  logic signed [PW-1:0] prod    [N];
  logic signed [PW-1:0] prod_p2 [N];
  sample_t              y       [M];
  logic [M*W-1:0]       y_flat;
  logic [M*W-1:0]       z_p3;

  // The accumulated sum is exactly DEN*y, so the quotient has no remainder;
  // only the low W bits are kept (wrap, no saturation).
  function automatic sample_t descale_wrap(input logic signed [AW-1:0] a);
    logic signed [AW-1:0] q;
    q = a / AW'(DEN);
    return q[W-1:0];
  endfunction

  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign d[i] = D[(N-1-i)*W +: W];
  end

  wc_xform_in u_xform_in (
    .d (d),
    .v (v)
  );

  // S1: input transform
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (rst) v_p1[i] <= '0;
      else     v_p1[i] <= v[i];
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_mul
    localparam int U = g_xform(i, G0, G1, G2, G3);
    assign prod[i] = PW'(v_p1[i]) * PW'(U);
  end

  // S2: element-wise products
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (rst) prod_p2[i] <= '0;
      else     prod_p2[i] <= prod[i];
    end
  end

  // Intermediate terms may exceed AW bits, but the ring arithmetic still
  // lands on the exact DEN*y, which always fits.
  for (genvar r = 0; r < M; r++) begin : g_out
    logic signed [AW-1:0] term [N];
    logic signed [AW-1:0] sum;

    for (genvar i = 0; i < N; i++) begin : g_tap
      localparam int A = at_coef(r, i);
      assign term[i] = AW'(A) * AW'(prod_p2[i]);
    end

    always_comb begin
      sum = '0;
      for (int i = 0; i < N; i++) sum = sum + term[i];
    end

    assign y[r] = descale_wrap(sum);
  end

  always_comb begin
    y_flat = '0;
    for (int r = 0; r < M; r++) y_flat[(M-1-r)*W +: W] = y[r];
  end

  // S3: output transform, de-scale and wrap
  always_ff @(posedge clk) begin
    if (rst) z_p3 <= '0;
    else     z_p3 <= y_flat;
  end

  assign Z = z_p3;

endmodule

// File: tb/tb_wc_core.sv
// Bench for wc_core: a direct-form correlation model delayed by three edges,
// checked every cycle, plus hand-computed vectors for two tap sets.
module tb_wc_core;

  localparam int W  = wc_pkg::W;
  localparam int HN = 1024;

  logic           clk = 1'b0;
  logic           rst;
  logic [9*W-1:0] D;
  logic [6*W-1:0] Z;
  logic [6*W-1:0] Zw;

  int checks   = 0;
  int failures = 0;

  logic [9*W-1:0] hist_d [HN];
  logic           hist_r [HN];
  int             ne = 0;

  int tile_a [9] = '{2, -10, 3, 4, -13, -18, -16, -28, -11};
  int res_a  [6] = '{7, -44, -100, -140, -209, -178};
  int tile_b [9] = '{-19, -6, 3, -9, -12, 11, -4, 0, -7};
  int res_b  [6] = '{-58, -75, -7, -16, -2, -25};
  int tile_n [9] = '{-512, 0, 0, 0, 0, 0, 0, 0, 0};
  int res_n  [6] = '{-512, 0, 0, 0, 0, 0};

  wc_core #(.G0(1), .G1(2), .G2(3), .G3(4)) dut (
    .clk (clk),
    .rst (rst),
    .D   (D),
    .Z   (Z)
  );

  wc_core #(.G0(511), .G1(511), .G2(511), .G3(511)) dut_w (
    .clk (clk),
    .rst (rst),
    .D   (D),
    .Z   (Zw)
  );

  always #5 clk = ~clk;

  function automatic logic [9*W-1:0] pack9(input int t [9]);
    logic [9*W-1:0] r;
    for (int i = 0; i < 9; i++) r[(8-i)*W +: W] = W'(t[i]);
    return r;
  endfunction

  function automatic logic [6*W-1:0] pack6(input int t [6]);
    logic [6*W-1:0] r;
    for (int i = 0; i < 6; i++) r[(5-i)*W +: W] = W'(t[i]);
    return r;
  endfunction

  function automatic logic [9*W-1:0] fill9(input int v);
    int t [9];
    for (int i = 0; i < 9; i++) t[i] = v;
    return pack9(t);
  endfunction

  function automatic logic [6*W-1:0] fill6(input int v);
    int t [6];
    for (int i = 0; i < 6; i++) t[i] = v;
    return pack6(t);
  endfunction

  function automatic logic [9*W-1:0] rand_tile();
    logic [9*W-1:0] r;
    for (int i = 0; i < 9; i++) begin
      case ($urandom_range(0, 3))
        0:       r[i*W +: W] = W'(512);
        1:       r[i*W +: W] = W'(511);
        default: r[i*W +: W] = W'($urandom_range(0, 1023));
      endcase
    end
    return r;
  endfunction

  // Direct correlation with plain integers, then keep the low W bits.
  function automatic logic [6*W-1:0] direct(input logic [9*W-1:0] dv, input int g0,
                                            input int g1, input int g2, input int g3);
    int             dd [9];
    int             g  [4];
    int             y;
    logic [31:0]    yb;
    logic [6*W-1:0] z;
    g[0] = g0; g[1] = g1; g[2] = g2; g[3] = g3;
    for (int i = 0; i < 9; i++) dd[i] = int'($signed(dv[(8-i)*W +: W]));
    z = '0;
    for (int i = 0; i < 6; i++) begin
      y = 0;
      for (int k = 0; k < 4; k++) y = y + dd[i+k] * g[k];
      yb = y;
      z[(5-i)*W +: W] = yb[W-1:0];
    end
    return z;
  endfunction

  // Output after edge e is the tile from edge e-2, or zero if reset hit any of those edges.
  function automatic logic [6*W-1:0] expect_z(input int e, input int g0, input int g1,
                                              input int g2, input int g3);
    if (e < 2) return '0;
    if (hist_r[e] || hist_r[e-1] || hist_r[e-2]) return '0;
    return direct(hist_d[e-2], g0, g1, g2, g3);
  endfunction

  task automatic chk(input string name, input logic [6*W-1:0] act, input logic [6*W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic cyc(input logic [9*W-1:0] dv, input logic r);
    D   = dv;
    rst = r;
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    if (ne < HN) begin
      hist_d[ne] = D;
      hist_r[ne] = rst;
    end
    ne = ne + 1;
  end

  always @(negedge clk) begin
    if (ne > 0 && ne <= HN) begin
      chk("model_g1234", Z,  expect_z(ne - 1, 1, 2, 3, 4));
      chk("model_g511",  Zw, expect_z(ne - 1, 511, 511, 511, 511));
    end
  end

  initial begin
    logic [9*W-1:0] ta, tb, tn, zero;
    ta   = pack9(tile_a);
    tb   = pack9(tile_b);
    tn   = pack9(tile_n);
    zero = '0;

    cyc(rand_tile(), 1'b1);
    chk("rst_hold0", Z, '0);
    cyc(rand_tile(), 1'b1);
    chk("rst_hold1", Z, '0);
    cyc(ta, 1'b0);
    chk("rst_after", Z, '0);
    cyc(ta, 1'b0);
    cyc(ta, 1'b0);
    chk("tile_a", Z, pack6(res_a));
    cyc(ta, 1'b0);
    chk("tile_a_hold", Z, pack6(res_a));

    cyc(zero, 1'b0);
    cyc(ta, 1'b0);
    cyc(tb, 1'b0);
    chk("b2b_pre", Z, '0);
    cyc(zero, 1'b0);
    chk("b2b_a", Z, pack6(res_a));
    cyc(zero, 1'b0);
    chk("b2b_b", Z, pack6(res_b));
    cyc(zero, 1'b0);
    chk("b2b_post", Z, '0);

    cyc(tn, 1'b0);
    cyc(zero, 1'b0);
    cyc(zero, 1'b0);
    chk("most_neg", Z, pack6(res_n));
    chk("most_neg_w", Zw, pack6(res_n));

    cyc(fill9(-512), 1'b0);
    cyc(fill9(511), 1'b0);
    cyc(zero, 1'b0);
    chk("wrap_neg", Z, fill6(0));
    chk("wrap_neg_w", Zw, fill6(0));
    cyc(zero, 1'b0);
    chk("wrap_pos", Z, fill6(-10));
    chk("wrap_pos_w", Zw, fill6(4));

    cyc(ta, 1'b0);
    cyc(tb, 1'b0);
    cyc(ta, 1'b1);
    chk("mid_rst0", Z, '0);
    cyc(tb, 1'b0);
    chk("mid_rst1", Z, '0);
    cyc(tb, 1'b0);
    chk("mid_rst2", Z, '0);
    cyc(tb, 1'b0);
    chk("mid_rst_refill", Z, pack6(res_b));

    for (int n = 0; n < 60; n++) begin
      cyc(rand_tile(), ($urandom_range(0, 9) == 0));
    end
    cyc(zero, 1'b0);
    cyc(zero, 1'b0);
    cyc(zero, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
